// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stim_sequencer
// Description : Parametrised bring-up stimulus generator. It produces the
//               initial DUT reset, a round-robin burst of ack pulses, a soak
//               interval and a train of repeated reset pulses. It runs
//               one-shot or continuously.
// Revision    : 1.0 - initial release
// ============================================================================
module stim_sequencer #(
  parameter int CHANNELS        = 1,
  parameter int CW              = 16,
  parameter int INIT_RST_CYCLES = 4,
  parameter int PRE_ACK_CYCLES  = 10,
  parameter int ACK_HIGH        = 2,
  parameter int ACK_LOW         = 10,
  parameter int ACK_COUNT       = 5,
  parameter int SOAK_CYCLES     = 1750,
  parameter int PULSE_RST_LOW   = 7,
  parameter int PULSE_GAP       = 750,
  parameter int PULSE_COUNT     = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic [CHANNELS-1:0] chan_mask,
  output logic                dut_rst_n,
  output logic [CHANNELS-1:0] ack,
  output logic                busy,
  output logic                done,
  output logic [3:0]          phase,
  output logic [CW-1:0]       pulse_idx
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // True when v is representable in a CW-bit counter.
  function automatic bit fits(input int v);
    return (v >= 0) && (longint'(v) < (longint'(1) << CW));
  endfunction

  // Reject unusable parameter sets at elaboration time.
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("stim_sequencer: CHANNELS must be in 1..16");
  end
  if (CW < 1 || CW > 31) begin : g_bad_cw
    $error("stim_sequencer: CW must be in 1..31");
  end
  if (INIT_RST_CYCLES < 1 || PRE_ACK_CYCLES < 1 || ACK_HIGH < 1 || ACK_LOW < 1 ||
      SOAK_CYCLES < 1 || PULSE_RST_LOW < 1 || PULSE_GAP < 1) begin : g_bad_zero
    $error("stim_sequencer: cycle parameters must be at least 1");
  end
  if (!fits(INIT_RST_CYCLES) || !fits(PRE_ACK_CYCLES) || !fits(ACK_HIGH) ||
      !fits(ACK_LOW) || !fits(ACK_COUNT) || !fits(SOAK_CYCLES) ||
      !fits(PULSE_RST_LOW) || !fits(PULSE_GAP) || !fits(PULSE_COUNT)) begin : g_bad_range
    $error("stim_sequencer: parameter value does not fit in CW bits");
  end

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT_RST = 4'd1,
    S_PRE_ACK  = 4'd2,
    S_ACK_HI   = 4'd3,
    S_ACK_LO   = 4'd4,
    S_SOAK     = 4'd5,
    S_PULSE_LO = 4'd6,
    S_PULSE_HI = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  // Counter reload values: a state of length L loads L-1 and leaves at 0.
  localparam logic [CW-1:0] c_init   = CW'(INIT_RST_CYCLES - 1);
  localparam logic [CW-1:0] c_pre    = CW'(PRE_ACK_CYCLES - 1);
  localparam logic [CW-1:0] c_ack_hi = CW'(ACK_HIGH - 1);
  localparam logic [CW-1:0] c_ack_lo = CW'(ACK_LOW - 1);
  localparam logic [CW-1:0] c_soak   = CW'(SOAK_CYCLES - 1);
  localparam logic [CW-1:0] c_pls_lo = CW'(PULSE_RST_LOW - 1);
  localparam logic [CW-1:0] c_pls_hi = CW'(PULSE_GAP - 1);
  localparam logic [CW-1:0] c_ack_n  = CW'(ACK_COUNT - 1);
  localparam logic [CW-1:0] c_pls_n  = CW'(PULSE_COUNT - 1);
  // Starting the search from the top channel makes the first ack land on the
  // lowest set bit of the mask.
  localparam logic [IW-1:0] c_last   = IW'(CHANNELS - 1);

  state_t              state;
  state_t              nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       rep;
  logic [CHANNELS-1:0] mask;
  logic [IW-1:0]       last;
  logic [IW-1:0]       sel_next;
  logic [CHANNELS-1:0] sel_onehot;

  // Cycle count to load when a state is entered.
  function automatic logic [CW-1:0] load_for(input state_t s);
    case (s)
      S_INIT_RST: return c_init;
      S_PRE_ACK:  return c_pre;
      S_ACK_HI:   return c_ack_hi;
      S_ACK_LO:   return c_ack_lo;
      S_SOAK:     return c_soak;
      S_PULSE_LO: return c_pls_lo;
      S_PULSE_HI: return c_pls_hi;
      default:    return '0;
    endcase
  endfunction

  // Next set bit of m strictly above 'from', wrapping round to the lowest.
  function automatic logic [IW-1:0] find_next(input logic [CHANNELS-1:0] m,
                                               input logic [IW-1:0] from);
    logic [IW-1:0]       r;
    logic [CHANNELS-1:0] sh;
    logic                found;
    int                  j;
    r     = from;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      j = int'(from) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      sh = m >> j;
      if (!found && sh[0]) begin
        r     = IW'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Channel that the next ack pulse will use.
  always_comb begin
    sel_next   = find_next(mask, last);
    sel_onehot = CHANNELS'(1) << sel_next;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (start) nxt = S_INIT_RST;
      S_INIT_RST: if (cnt == '0) nxt = S_PRE_ACK;
      S_PRE_ACK:  if (cnt == '0) nxt = (ACK_COUNT > 0) ? S_ACK_HI : S_SOAK;
      S_ACK_HI:   if (cnt == '0) nxt = S_ACK_LO;
      S_ACK_LO:   if (cnt == '0) nxt = (rep == '0) ? S_SOAK : S_ACK_HI;
      S_SOAK:     if (cnt == '0) nxt = (PULSE_COUNT > 0) ? S_PULSE_LO : S_DONE;
      S_PULSE_LO: if (cnt == '0) nxt = S_PULSE_HI;
      S_PULSE_HI: if (cnt == '0) nxt = (rep == '0) ? S_DONE : S_PULSE_LO;
      S_DONE:     nxt = continuous ? S_INIT_RST : S_IDLE;
      default:    nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  // State, counters and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rep       <= '0;
      mask      <= '0;
      last      <= c_last;
      dut_rst_n <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
    end else begin
      state     <= nxt;
      dut_rst_n <= !(nxt == S_INIT_RST || nxt == S_PULSE_LO);
      busy      <= (nxt != S_IDLE);
      done      <= (nxt == S_DONE);

      if (nxt != state)   cnt <= load_for(nxt);
      else if (cnt != '0) cnt <= cnt - CW'(1);

      // Repeat counter: ack pulses first, reset pulses afterwards.
      if (state == S_PRE_ACK && nxt == S_ACK_HI)        rep <= c_ack_n;
      else if (state == S_ACK_LO && nxt == S_ACK_HI)    rep <= rep - CW'(1);
      else if (state == S_SOAK && nxt == S_PULSE_LO)    rep <= c_pls_n;
      else if (state == S_PULSE_HI && nxt == S_PULSE_LO) rep <= rep - CW'(1);

      // Every sequence start (fresh or continuous) re-latches the mask.
      if (nxt == S_INIT_RST && state != S_INIT_RST) begin
        mask      <= chan_mask;
        last      <= c_last;
        pulse_idx <= '0;
      end else if (state == S_PULSE_HI && nxt == S_PULSE_LO) begin
        pulse_idx <= pulse_idx + CW'(1);
      end

      // Select and hold one ack channel for the whole high time.
      if (nxt == S_ACK_HI && state != S_ACK_HI) begin
        last <= sel_next;
        ack  <= (|mask) ? sel_onehot : '0;
      end else if (nxt != S_ACK_HI) begin
        ack  <= '0;
      end
    end
  end

  assign phase = state;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stim_sequencer
// Description : Directed self-checking bench for stim_sequencer using the
//               small-parameter timing (done at cycle 205, or 145 without
//               acks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_sequencer;

  logic        clk;
  logic        rst;
  // Instance A: four channels, five acks.
  logic        start_a, abort_a, cont_a;
  logic [3:0]  mask_a;
  logic        rstn_a, busy_a, done_a;
  logic [3:0]  ack_a, phase_a;
  logic [15:0] pidx_a;
  // Instance B: one channel, ack phase skipped.
  logic        start_b, abort_b, cont_b;
  logic        mask_b;
  logic        rstn_b, busy_b, done_b;
  logic        ack_b;
  logic [3:0]  phase_b;
  logic [15:0] pidx_b;

  int total = 0;
  int bad   = 0;

  stim_sequencer #(
    .CHANNELS(4), .CW(16), .INIT_RST_CYCLES(4), .PRE_ACK_CYCLES(10),
    .ACK_HIGH(2), .ACK_LOW(10), .ACK_COUNT(5), .SOAK_CYCLES(20),
    .PULSE_RST_LOW(7), .PULSE_GAP(30), .PULSE_COUNT(3)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .continuous(cont_a), .chan_mask(mask_a), .dut_rst_n(rstn_a),
    .ack(ack_a), .busy(busy_a), .done(done_a), .phase(phase_a),
    .pulse_idx(pidx_a)
  );

  stim_sequencer #(
    .CHANNELS(1), .CW(16), .INIT_RST_CYCLES(4), .PRE_ACK_CYCLES(10),
    .ACK_HIGH(2), .ACK_LOW(10), .ACK_COUNT(0), .SOAK_CYCLES(20),
    .PULSE_RST_LOW(7), .PULSE_GAP(30), .PULSE_COUNT(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .continuous(cont_b), .chan_mask(mask_b), .dut_rst_n(rstn_b),
    .ack(ack_b), .busy(busy_b), .done(done_b), .phase(phase_b),
    .pulse_idx(pidx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived {dut_rst_n, busy, done, ack} for instance A; ev/od are the
  // one-hot ack for even/odd numbered pulses.
  function automatic logic [6:0] exp_a(input int c, input logic [3:0] ev, input logic [3:0] od);
    logic       rn;
    logic [3:0] a;
    rn = !((c <= 3) || (c >= 94 && c <= 100) || (c >= 131 && c <= 137) ||
           (c >= 168 && c <= 174));
    a = 4'b0000;
    for (int k = 0; k < 5; k++)
      if (c == 14 + 12 * k || c == 15 + 12 * k) a = (k % 2 == 0) ? ev : od;
    return {rn, (c <= 205), (c == 205), a};
  endfunction

  // One full one-shot run on instance A with per-cycle and key-point checks.
  task automatic run_a(input logic [3:0] m, input logic [3:0] ev, input logic [3:0] od);
    mask_a  = m;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c <= 206; c++) begin
      check($sformatf("a_m%0h_cyc%0d", m, c), {rstn_a, busy_a, done_a, ack_a}, exp_a(c, ev, od));
      case (c)
        0:   check("a_phase0", phase_a, 4'd1);
        4:   check("a_phase4", phase_a, 4'd2);
        14:  check("a_phase14", phase_a, 4'd3);
        16:  check("a_phase16", phase_a, 4'd4);
        74:  check("a_phase74", phase_a, 4'd5);
        94:  begin check("a_phase94", phase_a, 4'd6); check("a_pidx94", pidx_a, 16'd0); end
        101: check("a_phase101", phase_a, 4'd7);
        131: check("a_pidx131", pidx_a, 16'd1);
        168: check("a_pidx168", pidx_a, 16'd2);
        205: begin check("a_phase205", phase_a, 4'd8); check("a_pidx205", pidx_a, 16'd2); end
        206: check("a_phase206", phase_a, 4'd0);
        default: ;
      endcase
      tick();
    end
  endtask

  initial begin
    logic seen_done;
    logic rn;
    rst = 1'b1;
    start_a = 0; abort_a = 0; cont_a = 0; mask_a = 4'b0000;
    start_b = 0; abort_b = 0; cont_b = 0; mask_b = 1'b0;

    // Reset state.
    tick();
    check("rst_rstn", rstn_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_phase", phase_a, 4'd0);
    check("rst_ack", ack_a, 4'd0);
    check("rst_pidx", pidx_a, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rel_rstn", rstn_a, 1'b1);
    check("rel_busy", busy_a, 1'b0);

    // Timing on one channel, round-robin 1,3,1,3,1, and an all-zero mask.
    run_a(4'b0001, 4'b0001, 4'b0001);
    run_a(4'b1010, 4'b0010, 4'b1000);
    run_a(4'b0000, 4'b0000, 4'b0000);

    // Instance B: no acks, SOAK straight after PRE_ACK, done at 145.
    mask_b  = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c <= 146; c++) begin
      rn = !((c <= 3) || (c >= 34 && c <= 40) || (c >= 71 && c <= 77) ||
             (c >= 108 && c <= 114));
      check($sformatf("b_cyc%0d", c), {rstn_b, busy_b, done_b, ack_b},
            {rn, (c <= 145), (c == 145), 1'b0});
      if (c == 13) check("b_phase13", phase_b, 4'd2);
      if (c == 14) check("b_phase14", phase_b, 4'd5);
      if (c == 34) check("b_phase34", phase_b, 4'd6);
      tick();
    end

    // Continuous restart, then abort during the second run.
    mask_a  = 4'b0001;
    cont_a  = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 205; c++) tick();
    check("cont_done205", done_a, 1'b1);
    check("cont_phase205", phase_a, 4'd8);
    tick();
    check("cont_phase206", phase_a, 4'd1);
    check("cont_pidx206", pidx_a, 16'd0);
    check("cont_rstn206", rstn_a, 1'b0);
    check("cont_busy206", busy_a, 1'b1);
    for (int c = 206; c < 256; c++) tick();
    check("cont_ack_rel50", ack_a, 4'b0001);
    abort_a = 1'b1;
    cont_a  = 1'b0;
    tick();
    abort_a = 1'b0;
    check("abort_phase", phase_a, 4'd0);
    check("abort_rstn", rstn_a, 1'b1);
    check("abort_ack", ack_a, 4'd0);
    check("abort_busy", busy_a, 1'b0);
    seen_done = done_a;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen_done = seen_done | done_a;
    end
    check("abort_no_done", seen_done, 1'b0);
    check("abort_stays_idle", phase_a, 4'd0);

    // Asynchronous reset inside PULSE_LO at cycle 100.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    check("pre_rst_phase100", phase_a, 4'd6);
    #2 rst = 1'b1;
    #1;
    check("async_phase", phase_a, 4'd0);
    check("async_rstn", rstn_a, 1'b0);
    check("async_busy", busy_a, 1'b0);
    check("async_pidx", pidx_a, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_rstn", rstn_a, 1'b1);
    for (int c = 0; c < 5; c++) tick();
    check("post_rst_idle", busy_a, 1'b0);

    // A start pulse while busy must not restart the sequence.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("ign_phase11", phase_a, 4'd2);
    for (int c = 11; c < 14; c++) tick();
    check("ign_phase14", phase_a, 4'd3);
    check("ign_ack14", ack_a, 4'b0001);
    for (int c = 14; c < 205; c++) tick();
    check("ign_done205", done_a, 1'b1);
    tick();
    check("ign_busy206", busy_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
